regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
Round-robin arbiter for the single register-file write port. Up to NUM_REQ writeback sources compete for the port: ALU, multiply/divide, load unit and link-write. Each source presents rd/data under a valid/ready handshake. The winner is registered onto the port with a one-hot 32-bit write-enable vector that drives the per-register write enables directly. Writes to register 0 are consumed but suppressed.

Parameters:
NUM_REQ, 4, number of writeback requesters (2..8)
DATA_W, 32, writeback data width
MAX_BURST, 4, maximum consecutive grants to one requester; used only when WB_ARB_BURST_EN is defined (1..15)

Ports:
clock  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  pipeline stall; blocks all grants while high
req_valid  in  NUM_REQ  per-requester valid
req_ready  out  NUM_REQ  per-requester ready, combinational, at most one bit high
req_rd  in  5*NUM_REQ  destination register; requester i occupies bits [5i+4:5i]
req_data  in  DATA_W*NUM_REQ  write data; requester i occupies slice i
wb_we  out  1  registered write strobe
wb_rd  out  5  registered destination register
wb_data  out  DATA_W  registered write data
wb_we_onehot  out  32  registered decoded enable; bit wb_rd set when wb_we=1, else all zero
wb_grant_id  out  clog2(NUM_REQ) (min 1)  registered index of the winning requester

Behaviour:
- Reset (async assert, synchronous-to-clock deassert handled upstream):
  - wb_we=0, wb_rd=0, wb_data=0, wb_we_onehot=0, wb_grant_id=0.
  - rr_ptr=0; burst counter=0.
- Arbitration, combinational each cycle:
  - If stall=0 and any req_valid is high, grant g = first valid index scanning rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - req_ready[g]=1; all other ready bits 0.
  - If stall=1 or no valid requester, req_ready=0.
- Transfer: occurs when req_valid[g] & req_ready[g]. Latency is 1 cycle to the port. On the next clock edge:
  - wb_rd=req_rd[g], wb_data=req_data[g], wb_grant_id=g.
  - If req_rd[g]!=0: wb_we=1 and wb_we_onehot=1<<req_rd[g].
  - If req_rd[g]==0: wb_we=0 and wb_we_onehot=0. The request is still consumed (ready was given).
  - rr_ptr <= (g+1) mod NUM_REQ. Wrap from NUM_REQ-1 to 0.
- No transfer cycle:
  - wb_we=0 and wb_we_onehot=0 on the next edge.
  - wb_rd, wb_data and wb_grant_id hold their previous values.
  - rr_ptr holds.
- Requester rules:
  - Once valid is raised, rd/data are stable and valid stays high until ready is seen.
  - The arbiter never drops an asserted, unserved request.
- Stall:
  - A stall asserted in the same cycle as a would-be grant suppresses that grant; the request waits.
  - rr_ptr and the burst counter hold during stall.
- Fairness: with all NUM_REQ requesters continuously valid, each is granted exactly once per NUM_REQ transfers.
- Throughput: one transfer per unstalled cycle; no bubbles between back-to-back grants.
- Invariant: wb_we_onehot is always zero or exactly one-hot, and bit 0 is never set.
- Reset mid-operation: outputs clear immediately; pending requests are re-arbitrated from rr_ptr=0 after release.

Optional Feature:
Macro: WB_ARB_BURST_EN
- Defined:
  - After a transfer to g, if req_valid[g] is still high next cycle, g keeps priority.
  - This continues until it has received MAX_BURST consecutive transfers, or drops valid.
  - rr_ptr then advances to g+1; the burst counter resets to 0.
  - Stalled cycles do not break or count toward a burst.
- Not defined: rr_ptr advances after every transfer; no burst counter exists.

Test Plan:
1. Reset with req_valid=4'b1111 held → all outputs 0 during reset. First grant after release goes to requester 0; wb_we=1 one cycle later.
2. Requesters 0-3 all valid continuously with rd=1,2,3,4 (macro off) → wb_grant_id sequence 0,1,2,3,0,… and wb_we_onehot sequence 0x2,0x4,0x8,0x10,…, one per cycle.
3. Only requester 2 valid, rd=0, data=0xDEADBEEF → req_ready[2]=1 for one cycle; next cycle wb_we=0 and wb_we_onehot=0.
4. rr_ptr=3 and requesters 1 and 3 valid → 3 granted first, then 1 (wrap-around). Then with only requester 1 valid, rd=31 → wb_we_onehot=0x80000000.
5. stall=1 for 3 cycles with requester 1 valid → req_ready=0 and wb_we=0 throughout. Stall drops → grant to 1 and write appears on the following edge; rr_ptr unchanged during the stall.
6. WB_ARB_BURST_EN, MAX_BURST=4, requesters 0 and 1 continuously valid → grants 0,0,0,0,1,1,1,1,0,…

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter for the single register-file write port.
// Winner is registered onto the port one cycle after its valid/ready handshake,
// with a decoded one-hot write enable; writes to register 0 are consumed but
// suppressed.
// Optional macro WB_ARB_BURST_EN: a granted requester that stays valid keeps
// priority for up to MAX_BURST consecutive transfers.
module regfile_wb_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic                                           stall,
    input  logic [NUM_REQ-1:0]                             req_valid,
    output logic [NUM_REQ-1:0]                             req_ready,
    input  logic [5*NUM_REQ-1:0]                           req_rd,
    input  logic [DATA_W*NUM_REQ-1:0]                      req_data,
    output logic                                           wb_we,
    output logic [4:0]                                     wb_rd,
    output logic [DATA_W-1:0]                              wb_data,
    output logic [31:0]                                    wb_we_onehot,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] wb_grant_id
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("regfile_wb_arbiter: NUM_REQ must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_max_burst
        $error("regfile_wb_arbiter: MAX_BURST must be in 1..15");
    end

    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     cand;
    logic              grant_found;
    logic [GW-1:0]     grant_idx;
    logic [4:0]        sel_rd;
    logic [DATA_W-1:0] sel_data;

    logic              wb_we_q, wb_we_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [31:0]       wb_onehot_q, wb_onehot_d;
    logic [GW-1:0]     wb_gid_q, wb_gid_d;

    function automatic logic [GW-1:0] ptr_next(input logic [GW-1:0] p);
        return (32'(p) == 32'(NUM_REQ - 1)) ? '0 : p + GW'(1);
    endfunction

    // Pick the first valid requester scanning from rr_ptr; stall blocks any grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = GW'((32'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
        if (stall) begin
            grant_found = 1'b0;
            grant_idx   = '0;
        end
    end

    // Decode the grant into ready bits and select the winner's rd/data.
    always_comb begin
        req_ready = '0;
        sel_rd    = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_found && (grant_idx == GW'(i));
            if (grant_idx == GW'(i)) begin
                sel_rd   = req_rd[i*5 +: 5];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next port contents: strobe only for a transfer to a non-zero register.
    always_comb begin
        wb_we_d     = 1'b0;
        wb_onehot_d = '0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_gid_d    = wb_gid_q;
        if (grant_found) begin
            wb_rd_d   = sel_rd;
            wb_data_d = sel_data;
            wb_gid_d  = grant_idx;
            if (sel_rd != 5'd0) begin
                wb_we_d     = 1'b1;
                wb_onehot_d = 32'd1 << sel_rd;
            end
        end
    end

`ifdef WB_ARB_BURST_EN
    logic [3:0] burst_cnt_q, burst_cnt_d;
    logic [4:0] run_len;

    // While a burst is running rr_ptr parks on the owner, so the normal scan
    // grants it first; an owner that drops valid is skipped by the same scan,
    // which is why only the counter and pointer need explicit cleanup here.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        run_len     = 5'd1;
        if (grant_found) begin
            if (grant_idx == rr_ptr_q && burst_cnt_q != '0) begin
                run_len = 5'(burst_cnt_q) + 5'd1;
            end
            if (run_len >= 5'(MAX_BURST)) begin
                rr_ptr_d    = ptr_next(grant_idx);
                burst_cnt_d = '0;
            end else begin
                rr_ptr_d    = grant_idx;
                burst_cnt_d = run_len[3:0];
            end
        end else if (!stall && burst_cnt_q != '0 && !req_valid[rr_ptr_q]) begin
            rr_ptr_d    = ptr_next(rr_ptr_q);
            burst_cnt_d = '0;
        end
    end

    // Burst length register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            burst_cnt_q <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
        end
    end
`else
    // Plain round-robin: advance past the winner after every transfer.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = ptr_next(grant_idx);
        end
    end
`endif

    // Pointer and write-port registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            wb_onehot_q <= '0;
            wb_gid_q    <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            wb_we_q     <= wb_we_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_onehot_q <= wb_onehot_d;
            wb_gid_q    <= wb_gid_d;
        end
    end

    assign wb_we        = wb_we_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign wb_we_onehot = wb_onehot_q;
    assign wb_grant_id  = wb_gid_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios followed by randomized
// traffic with stalls and mid-run resets, checked against a request-list model.
module tb_regfile_wb_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 4;
    localparam int GW        = 2;

    logic                      clock;
    logic                      reset_n;
    logic                      stall;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [5*NUM_REQ-1:0]      req_rd;
    logic [DATA_W*NUM_REQ-1:0] req_data;
    logic                      wb_we;
    logic [4:0]                wb_rd;
    logic [DATA_W-1:0]         wb_data;
    logic [31:0]               wb_we_onehot;
    logic [GW-1:0]             wb_grant_id;

    regfile_wb_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rd      (req_rd),
        .req_data    (req_data),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .wb_we_onehot(wb_we_onehot),
        .wb_grant_id (wb_grant_id)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pending request per requester (held until granted).
    bit          act     [NUM_REQ];
    logic [4:0]  rq_rd   [NUM_REQ];
    logic [31:0] rq_data [NUM_REQ];

    // Reference model state.
    int          m_ptr;
    int          m_owner;
    int          m_len;
    logic        m_we;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    int          m_gid;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]                 = act[i];
            req_rd[i*5 +: 5]             = rq_rd[i];
            req_data[i*DATA_W +: DATA_W] = rq_data[i];
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] rd, input logic [31:0] data);
        act[i]     = 1'b1;
        rq_rd[i]   = rd;
        rq_data[i] = data;
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NUM_REQ; i++) begin
            act[i]     = 1'b0;
            rq_rd[i]   = '0;
            rq_data[i] = '0;
        end
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_owner = -1;
        m_len   = 0;
        m_we    = 1'b0;
        m_rd    = '0;
        m_data  = '0;
        m_gid   = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] exp_oh;
        exp_oh = '0;
        if (m_we) exp_oh = 32'(2 ** int'(m_rd));
        check_val({tag, "_we"},     64'(wb_we),        64'(m_we));
        check_val({tag, "_onehot"}, 64'(wb_we_onehot), 64'(exp_oh));
        check_val({tag, "_rd"},     64'(wb_rd),        64'(m_rd));
        check_val({tag, "_data"},   64'(wb_data),      64'(m_data));
        check_val({tag, "_gid"},    64'(wb_grant_id),  64'(m_gid));
    endtask

    // Assert reset asynchronously, hold it for n edges, release after an edge.
    task automatic do_reset(input int n);
        drive();
        reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("rst");
        repeat (n) begin
            @(posedge clock);
            #1;
            check_outputs("rst_hold");
        end
        reset_n = 1'b1;
    endtask

    // One clock: drive pending requests, check ready against the model's
    // choice, then check the port one edge later.
    task automatic cycle();
        int g;
        logic [NUM_REQ-1:0] exp_ready;
        g = -1;
        drive();
        #1;
        if (!stall) begin
`ifdef WB_ARB_BURST_EN
            if (m_owner >= 0 && !act[m_owner]) begin
                m_ptr   = (m_owner + 1) % NUM_REQ;
                m_owner = -1;
                m_len   = 0;
            end
            if (m_owner >= 0) g = m_owner;
`endif
            for (int k = 0; k < NUM_REQ; k++) begin
                if (g < 0 && act[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        check_val("ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
            m_rd   = rq_rd[g];
            m_data = rq_data[g];
            m_gid  = g;
            m_we   = (rq_rd[g] != 5'd0);
`ifdef WB_ARB_BURST_EN
            if (g == m_owner) begin
                m_len++;
            end else begin
                m_owner = g;
                m_len   = 1;
            end
            if (m_len == MAX_BURST) begin
                m_owner = -1;
                m_len   = 0;
                m_ptr   = (g + 1) % NUM_REQ;
            end
`else
            m_ptr = (g + 1) % NUM_REQ;
`endif
        end else begin
            m_we = 1'b0;
        end
        @(posedge clock);
        #1;
        check_outputs("wb");
        if (g >= 0) act[g] = 1'b0;
    endtask

    initial begin
        reset_n = 1'b1;
        stall   = 1'b0;
        clear_reqs();
        model_reset();
        drive();
        #2;

        // All four valid through reset; requester 0 wins first.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 5'(i + 1), 32'h1000 + 32'(i));
        do_reset(3);
        cycle();
        check_val("t1_gid", 64'(wb_grant_id), 64'd0);
        check_val("t1_we",  64'(wb_we),       64'd1);

        // Continuous traffic rotates through all requesters.
        for (int k = 1; k <= 8; k++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!act[i]) set_req(i, 5'(i + 1), 32'h2000 + 32'(k));
            cycle();
`ifndef WB_ARB_BURST_EN
            check_val("t2_gid",    64'(wb_grant_id),  64'(k % 4));
            check_val("t2_onehot", 64'(wb_we_onehot), 64'(32'd2 << (k % 4)));
`endif
        end

        // Write to register 0 is consumed without a strobe.
        clear_reqs();
        do_reset(1);
        set_req(2, 5'd0, 32'hDEADBEEF);
        cycle();
        check_val("t3_we",     64'(wb_we),        64'd0);
        check_val("t3_onehot", 64'(wb_we_onehot), 64'd0);
        check_val("t3_data",   64'(wb_data),      64'hDEADBEEF);
        cycle();

        // Wrap-around from pointer 3, then the top register.
        set_req(1, 5'd5, 32'h11);
        set_req(3, 5'd6, 32'h33);
        cycle();
        check_val("t4_first",  64'(wb_grant_id), 64'd3);
        cycle();
        check_val("t4_second", 64'(wb_grant_id), 64'd1);
        set_req(1, 5'd31, 32'h31);
        cycle();
        check_val("t4_r31", 64'(wb_we_onehot), 64'h80000000);
        cycle();

        // Stall holds off a pending request.
        set_req(1, 5'd9, 32'h99);
        stall = 1'b1;
        repeat (3) begin
            cycle();
            check_val("t5_stall_we", 64'(wb_we), 64'd0);
        end
        stall = 1'b0;
        cycle();
        check_val("t5_gid", 64'(wb_grant_id), 64'd1);
        check_val("t5_we",  64'(wb_we),       64'd1);

`ifdef WB_ARB_BURST_EN
        // Bursts of MAX_BURST alternate between two always-valid requesters.
        clear_reqs();
        do_reset(1);
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 2; i++)
                if (!act[i]) set_req(i, 5'(i + 3), 32'h3000 + 32'(k));
            cycle();
            check_val("t6_gid", 64'(wb_grant_id), 64'((k / MAX_BURST) % 2));
        end
`endif

        // Randomized traffic with stalls and occasional resets.
        clear_reqs();
        do_reset(1);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 199) == 0) do_reset(int'($urandom_range(1, 2)));
            stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!act[i] && $urandom_range(0, 2) != 0)
                    set_req(i, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                            32'($urandom));
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
